// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// AluArbiter (module alu_arbiter)
// Shares one external combinational ALU between two requesters. Requests are
// accepted one at a time. When both requesters are valid, round-robin priority
// decides which one is granted. The ALU result is registered and presented on
// a valid/ready response channel.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0_* / req1_*            valid/ready request channels carrying operands
//                              a, b (4 bits each) and opcode op (2 bits)
//   alu_in1, alu_in2, alu_op   operands and opcode driven to the shared ALU
//   alu_out, alu_err           combinational result and overflow from the ALU
//   rsp_valid, rsp_ready       response handshake
//   rsp_id                     requester that owns the response
//   rsp_data, rsp_err          registered ALU result and overflow flag
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_op,
  output logic [3:0] alu_in1,
  output logic [3:0] alu_in2,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_out,
  input  logic       alu_err,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_data,
  output logic       rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       rrPtr_q;
  logic [3:0] opA_q, opB_q;
  logic [1:0] op_q;
  logic       id_q;
  logic [3:0] rspData_q;
  logic       rspErr_q;
  logic       grant0, grant1;

  // Next-state and grant decision. A lone requester is granted regardless of
  // the pointer. The pointer only breaks ties when both requesters are valid.
  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          if (rrPtr_q) grant1 = 1'b1;
          else         grant0 = 1'b1;
        end else if (req0_valid) begin
          grant0 = 1'b1;
        end else if (req1_valid) begin
          grant1 = 1'b1;
        end
        if (grant0 || grant1) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand latch, round-robin pointer and result capture. On a grant
  // the pointer moves to the requester that lost, so it gets the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rrPtr_q   <= RR_INIT;
      opA_q     <= 4'd0;
      opB_q     <= 4'd0;
      op_q      <= 2'd0;
      id_q      <= 1'b0;
      rspData_q <= 4'd0;
      rspErr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant0) begin
        opA_q   <= req0_a;
        opB_q   <= req0_b;
        op_q    <= req0_op;
        id_q    <= 1'b0;
        rrPtr_q <= 1'b1;
      end else if (grant1) begin
        opA_q   <= req1_a;
        opB_q   <= req1_b;
        op_q    <= req1_op;
        id_q    <= 1'b1;
        rrPtr_q <= 1'b0;
      end
      if (state_q == EXEC) begin
        rspData_q <= alu_out;
        rspErr_q  <= alu_err;
      end
    end
  end

  // Ready is qualified with rst_n. This keeps it low while reset is asserted,
  // even though the state register already reads IDLE during reset.
  assign req0_ready = grant0 & rst_n;
  assign req1_ready = grant1 & rst_n;

  assign alu_in1   = opA_q;
  assign alu_in2   = opB_q;
  assign alu_op    = op_q;

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = rspData_q;
  assign rsp_err   = rspErr_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for alu_arbiter. It drives directed vectors with hand-computed
// expected values. A small combinational ALU model stands in for the external
// ALU: add and sub report signed overflow, nand and xor never set the error flag.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic [3:0] alu_in1, alu_in2, alu_out;
  logic [1:0] alu_op;
  logic       alu_err;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [3:0] rsp_data;

  int compareCount  = 0;
  int mismatchCount = 0;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_err(alu_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Stand-in for the external ALU
  always_comb begin
    alu_out = 4'd0;
    alu_err = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_out = alu_in1 + alu_in2;
        alu_err = (alu_in1[3] == alu_in2[3]) && (alu_out[3] != alu_in1[3]);
      end
      OP_SUB: begin
        alu_out = alu_in1 - alu_in2;
        alu_err = (alu_in1[3] != alu_in2[3]) && (alu_out[3] != alu_in1[3]);
      end
      OP_NAND: alu_out = ~(alu_in1 & alu_in2);
      default: alu_out = alu_in1 ^ alu_in2;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                               input logic [1:0] op0, input logic v1, input logic [3:0] a1,
                               input logic [3:0] b1, input logic [1:0] op1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
  endtask

  // Advance one clock and settle just after the active edge
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    applyStimulus(1'b1, 4'd3, 4'd4, OP_ADD, 1'b0, 4'd0, 4'd0, OP_ADD);
    #2;
    // Reset values, with a request already pending
    checkOutput("rst_ready0", {7'd0, req0_ready}, 8'd0);
    checkOutput("rst_ready1", {7'd0, req1_ready}, 8'd0);
    checkOutput("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    checkOutput("rst_alu_in1", {4'd0, alu_in1}, 8'd0);
    checkOutput("rst_rsp_data", {4'd0, rsp_data}, 8'd0);
    waitCycle();
    waitCycle();

    // Single request: add 3+4
    $display("[TB] single request");
    rst_n = 1'b1;
    #1;
    checkOutput("single_ready0", {7'd0, req0_ready}, 8'd1);
    checkOutput("single_ready1", {7'd0, req1_ready}, 8'd0);
    waitCycle();
    req0_valid = 1'b0;
    #1;
    checkOutput("single_exec_ready0", {7'd0, req0_ready}, 8'd0);
    checkOutput("single_alu_in1", {4'd0, alu_in1}, 8'd3);
    checkOutput("single_alu_in2", {4'd0, alu_in2}, 8'd4);
    checkOutput("single_exec_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    waitCycle();
    checkOutput("single_rsp_valid", {7'd0, rsp_valid}, 8'd1);
    checkOutput("single_rsp_id", {7'd0, rsp_id}, 8'd0);
    checkOutput("single_rsp_data", {4'd0, rsp_data}, 8'd7);
    checkOutput("single_rsp_err", {7'd0, rsp_err}, 8'd0);
    waitCycle();
    checkOutput("single_rsp_drop", {7'd0, rsp_valid}, 8'd0);

    // Restore the reset pointer before the contention test
    rst_n = 1'b0;
    waitCycle();
    rst_n = 1'b1;

    // Contention: req0 add 7+1 (overflow), req1 xor 5^3; expect 0,1,0,1
    $display("[TB] contention");
    applyStimulus(1'b1, 4'd7, 4'd1, OP_ADD, 1'b1, 4'd5, 4'd3, OP_XOR);
    for (int g = 0; g < 4; g++) begin
      logic expId;
      expId = g[0];
      #1;
      checkOutput($sformatf("cont_ready0_%0d", g), {7'd0, req0_ready}, {7'd0, ~expId});
      checkOutput($sformatf("cont_ready1_%0d", g), {7'd0, req1_ready}, {7'd0, expId});
      waitCycle();
      checkOutput($sformatf("cont_exec_ready_%0d", g), {6'd0, req1_ready, req0_ready}, 8'd0);
      waitCycle();
      checkOutput($sformatf("cont_rsp_valid_%0d", g), {7'd0, rsp_valid}, 8'd1);
      checkOutput($sformatf("cont_rsp_id_%0d", g), {7'd0, rsp_id}, {7'd0, expId});
      checkOutput($sformatf("cont_rsp_data_%0d", g), {4'd0, rsp_data}, expId ? 8'd6 : 8'd8);
      checkOutput($sformatf("cont_rsp_err_%0d", g), {7'd0, rsp_err}, expId ? 8'd0 : 8'd1);
      waitCycle();
    end

    // Backpressure: req1 sub 2-5, consumer stalls 4 cycles, req1 keeps asking
    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD, 1'b1, 4'd2, 4'd5, OP_SUB);
    #1;
    checkOutput("bp_ready1", {7'd0, req1_ready}, 8'd1);
    waitCycle();
    waitCycle();
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("bp_rsp_valid_%0d", c), {7'd0, rsp_valid}, 8'd1);
      checkOutput($sformatf("bp_rsp_data_%0d", c), {4'd0, rsp_data}, 8'b0000_1101);
      checkOutput($sformatf("bp_rsp_err_%0d", c), {7'd0, rsp_err}, 8'd0);
      checkOutput($sformatf("bp_rsp_id_%0d", c), {7'd0, rsp_id}, 8'd1);
      checkOutput($sformatf("bp_ready_%0d", c), {6'd0, req1_ready, req0_ready}, 8'd0);
      waitCycle();
    end
    rsp_ready  = 1'b1;
    req1_valid = 1'b0;
    waitCycle();
    checkOutput("bp_accept", {7'd0, rsp_valid}, 8'd0);

    // Lone requester (req1, pointer 0), then a tie shows pointer stayed at 0
    $display("[TB] lone requester");
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD, 1'b1, 4'd5, 4'd3, OP_XOR);
    #1;
    checkOutput("lone_ready1", {7'd0, req1_ready}, 8'd1);
    checkOutput("lone_ready0", {7'd0, req0_ready}, 8'd0);
    waitCycle();
    req1_valid = 1'b0;
    waitCycle();
    checkOutput("lone_rsp_id", {7'd0, rsp_id}, 8'd1);
    checkOutput("lone_rsp_data", {4'd0, rsp_data}, 8'd6);
    waitCycle();
    applyStimulus(1'b1, 4'b1111, 4'b1010, OP_NAND, 1'b1, 4'd5, 4'd3, OP_XOR);
    #1;
    checkOutput("tie_ready0", {7'd0, req0_ready}, 8'd1);
    checkOutput("tie_ready1", {7'd0, req1_ready}, 8'd0);
    waitCycle();
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD, 1'b0, 4'd0, 4'd0, OP_ADD);
    waitCycle();
    checkOutput("nand_rsp_id", {7'd0, rsp_id}, 8'd0);
    checkOutput("nand_rsp_data", {4'd0, rsp_data}, 8'b0000_0101);
    checkOutput("nand_rsp_err", {7'd0, rsp_err}, 8'd0);
    waitCycle();

    // Reset in the middle of EXEC
    $display("[TB] reset mid-op");
    applyStimulus(1'b1, 4'd3, 4'd4, OP_ADD, 1'b0, 4'd0, 4'd0, OP_ADD);
    #1;
    checkOutput("mid_ready0", {7'd0, req0_ready}, 8'd1);
    waitCycle();
    checkOutput("mid_exec_alu_in1", {4'd0, alu_in1}, 8'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_alu_in1", {4'd0, alu_in1}, 8'd0);
    checkOutput("mid_alu_in2", {4'd0, alu_in2}, 8'd0);
    checkOutput("mid_rsp_data", {4'd0, rsp_data}, 8'd0);
    checkOutput("mid_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    checkOutput("mid_ready0_rst", {7'd0, req0_ready}, 8'd0);
    req0_valid = 1'b0;
    waitCycle();
    waitCycle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      waitCycle();
      checkOutput($sformatf("mid_no_rsp_%0d", c), {7'd0, rsp_valid}, 8'd0);
    end
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD, 1'b1, 4'd5, 4'd3, OP_XOR);
    #1;
    checkOutput("post_ready1", {7'd0, req1_ready}, 8'd1);
    waitCycle();
    req1_valid = 1'b0;
    waitCycle();
    checkOutput("post_rsp_valid", {7'd0, rsp_valid}, 8'd1);
    checkOutput("post_rsp_id", {7'd0, rsp_id}, 8'd1);
    checkOutput("post_rsp_data", {4'd0, rsp_data}, 8'd6);
    waitCycle();
    checkOutput("post_rsp_drop", {7'd0, rsp_valid}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
